row_shifter: RTL and testbench
==============================

# row_shifter

Collapses one completed line of the 10x20 Tetris board. When the line-check controller holds `clear` for row `row`, this block moves every row above it down by one, zeroes the top row, then raises `shift_done`. It sits between the line-check controller and the board row memory, and owns the memory write port for the duration of a shift.

## Interface
Parameters:
- `WIDTH`, default 10, board columns (bits per row word)
- `HEIGHT`, default 20, board rows; row 0 is the top, row `HEIGHT-1` is the bottom
- `ROW_W`, default 5, row index width, equal to `$clog2(HEIGHT)`

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `restart`  in  1  synchronous soft reset; driven by the controller's reset_shifter pulse
- `clear`  in  1  level shift request; held until `shift_done` is seen
- `row`  in  ROW_W  row to remove; sampled in S_IDLE only
- `rd_addr`  out  ROW_W  board read address; memory returns data one cycle later
- `rd_data`  in  WIDTH  board read data
- `wr_en`  out  1  board write strobe
- `wr_addr`  out  ROW_W  board write address
- `wr_data`  out  WIDTH  board write data
- `busy`  out  1  high in S_READ, S_WRITE and S_TOP
- `shift_done`  out  1  high in S_DONE

## Operation
Internal register:
- `cur`, ROW_W bits: the destination row currently being filled.

States:
- **S_IDLE**
  - If `clear` && !`restart`: `cur <= (row >= HEIGHT) ? HEIGHT-1 : row`.
  - Next state is S_TOP if the clamped row is 0, otherwise S_READ.
- **S_READ**
  - `rd_addr = cur-1`.
  - Next state is S_WRITE.
- **S_WRITE**
  - `wr_en=1`, `wr_addr=cur`, `wr_data=rd_data`.
  - `cur <= cur-1`.
  - Next state is S_TOP if `cur==1`, otherwise S_READ.
- **S_TOP**
  - `wr_en=1`, `wr_addr=0`, `wr_data=0`.
  - Next state is S_DONE.
- **S_DONE**
  - `shift_done=1`.
  - Next state is S_IDLE on `restart` or !`clear`; otherwise stays in S_DONE.

Other rules:
- `restart` in any state forces S_IDLE next cycle and suppresses `wr_en` in that cycle. `restart` has priority over `clear`.
- Outputs are combinational from state and `cur`. When `wr_en=0`, `rd_addr`, `wr_addr` and `wr_data` are 0, except `rd_addr` in S_READ.
- No arithmetic wraps: `cur` never decrements below 0, because S_WRITE exits at `cur==1`.
- The block does not re-check row contents. Whether the row was full is the controller's decision.

## Timing
- Reset values: state S_IDLE, `cur=0`, and all outputs 0.
- Latency: with `clear` first sampled high in S_IDLE at cycle 0, `shift_done` goes high at cycle 2y+2, where y is the clamped row. For y=0 this is cycle 2; for y=19 it is cycle 40.
- Writes: exactly y+1 writes per shift.
  - Descending addresses y, y-1, …, 1, one every second cycle.
  - Then address 0 with data 0.
- Each S_WRITE consumes `rd_data` for the address presented in the immediately preceding S_READ.
- `shift_done` stays high while `clear` stays high and `restart` stays low. It drops the cycle after either condition ends.
- `clear` held high in the cycle S_DONE exits to S_IDLE:
  - If that exit was caused by `restart`, S_IDLE sees `restart` low next cycle and starts a new shift. The controller must drop `clear` alongside `restart` to avoid this.
  - If the exit was caused by !`clear`, no shift starts, because `clear` is already low.
- `restart` mid-shift:
  - The shift aborts with the board partially shifted, and rows already written stay written.
  - `busy` falls on the next cycle.
  - `shift_done` is never raised for the aborted shift.
- `row` changes after the S_IDLE sample are ignored.

## Test plan
- **Mid-board shift.** Preload rows r=0..19 with data r+1; then `row=5`, `clear` high.
  - Writes: (5,5), (4,4), (3,3), (2,2), (1,1), (0,0).
  - `shift_done` at cycle 12.
  - Final rows 0..5 = 0,1,2,3,4,5; rows 6..19 unchanged.
- **Bottom row.** Preload as above; `row=19`.
  - 20 writes; `shift_done` at cycle 40.
  - Final row k = k for k≥1; row 0 = 0.
- **Top row.** `row=0`.
  - No reads; a single write (0, 0x000).
  - `shift_done` at cycle 2.
- **Out-of-range row.** `row=25`.
  - Behaves exactly as `row=19`, with the first write to address 19.
- **Restart mid-shift.** `row=10`; assert `restart` at cycle 5.
  - No `wr_en` at or after cycle 5; `busy` is 0 at cycle 6.
  - `shift_done` never rises.
  - A following `clear` with `row=3` completes normally at cycle 8 relative to its start.
- **Handshake release.** Shift `row=2`; hold `clear` 3 cycles past `shift_done`, then drop it.
  - `shift_done` stays high for those 3 cycles, then goes 0 the cycle after `clear` falls.
  - The block idles with no extra writes.

Source files
------------

// File: rtl/row_shifter_if.sv
// Board-side bus of the row shifter: controller handshake plus the row memory
// read/write ports. The shifter is the master; controller and memory are the slave side.
interface row_shifter_if #(
    parameter int WIDTH = 10,
    parameter int ROW_W = 5
);
    logic             restart;
    logic             clear;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic [ROW_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             shift_done;

    modport master (
        input  restart, clear, row, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data, busy, shift_done
    );

    modport slave (
        output restart, clear, row, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data, busy, shift_done
    );
endinterface

// File: rtl/row_shifter.sv
// Removes one board row by copying every row above it down one slot,
// bottom-up, then blanking the top row; owns the memory write port while busy.
module row_shifter #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int ROW_W  = 5
) (
    input  logic          clk,
    input  logic          reset,
    row_shifter_if.master bus
);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0] ONE_ROW   = ROW_W'(1);
    localparam logic [WIDTH-1:0] EMPTY_ROW = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TOP,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [ROW_W-1:0] cur, cur_next;
    logic [ROW_W-1:0] row_clamped;

    assign row_clamped = (bus.row > LAST_ROW) ? LAST_ROW : bus.row;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cur   <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        cur_next       = cur;
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.busy       = 1'b0;
        bus.shift_done = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.clear) begin
                    cur_next   = row_clamped;
                    state_next = (row_clamped == '0) ? S_TOP : S_READ;
                end
            end
            S_READ: begin
                bus.busy    = 1'b1;
                bus.rd_addr = cur - ONE_ROW;
                state_next  = S_WRITE;
            end
            S_WRITE: begin
                // rd_data holds the row above cur, fetched during S_READ
                bus.busy    = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = cur;
                bus.wr_data = bus.rd_data;
                cur_next    = cur - ONE_ROW;
                state_next  = (cur == ONE_ROW) ? S_TOP : S_READ;
            end
            S_TOP: begin
                bus.busy    = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_data = EMPTY_ROW;
                state_next  = S_DONE;
            end
            S_DONE: begin
                bus.shift_done = 1'b1;
                if (!bus.clear) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Soft reset wins over everything and blocks the write in flight.
        if (bus.restart) begin
            state_next  = S_IDLE;
            cur_next    = '0;
            bus.wr_en   = 1'b0;
            bus.wr_addr = '0;
            bus.wr_data = '0;
        end
    end
endmodule

// File: tb/tb_row_shifter.sv
// Directed bench for row_shifter: a board memory model, a write scoreboard fed
// from a shadow board, and cycle-exact checks of shift_done and busy.
module tb_row_shifter;
    localparam int WIDTH  = 10;
    localparam int HEIGHT = 20;
    localparam int ROW_W  = 5;

    typedef struct packed {
        logic [ROW_W-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic preload;

    row_shifter_if #(.WIDTH(WIDTH), .ROW_W(ROW_W)) bus ();

    row_shifter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem   [0:31];
    logic [WIDTH-1:0] model [0:HEIGHT-1];
    wr_t              exp_q [$];
    int               tests = 0;
    int               fails = 0;

    // Board memory: one-cycle read latency, preload writes row r = r+1
    always @(posedge clk) begin
        if (preload) begin
            for (int r = 0; r < 32; r++) mem[r] <= WIDTH'(r + 1);
        end else if (bus.wr_en === 1'b1) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        for (int r = 0; r < HEIGHT; r++) model[r] = WIDTH'(r + 1);
        @(negedge clk);
    endtask

    // Pops one expected write whenever the DUT strobes wr_en this cycle.
    task automatic observe();
        wr_t e;
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.wr_addr), 32'hffff);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                check("wr_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
    endtask

    // Writes row a with old row a-1 going bottom-up, then blanks row 0.
    task automatic push_shift(input int y);
        for (int a = y; a >= 1; a--) begin
            exp_q.push_back(wr_t'{addr: ROW_W'(a), data: model[a-1]});
            model[a] = model[a-1];
        end
        exp_q.push_back(wr_t'{addr: '0, data: '0});
        model[0] = '0;
    endtask

    // Starts a shift at the current negedge (cycle 0); returns the shift_done cycle.
    task automatic run_shift(input int r, output int done_k);
        int y;
        y = (r >= HEIGHT) ? HEIGHT - 1 : r;
        push_shift(y);
        bus.row   = ROW_W'(r);
        bus.clear = 1'b1;
        done_k    = -1;
        for (int k = 0; k < 100; k++) begin
            observe();
            if (k == 1) check("busy_start", 32'(bus.busy), 32'd1);
            if (bus.shift_done === 1'b1) begin
                done_k = k;
                break;
            end
            @(negedge clk);
            if (k == 2) bus.row = ROW_W'(7);  // late row changes must be ignored
        end
        check("done_cycle", 32'(done_k), 32'(2 * y + 2));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic release_clear();
        bus.clear = 1'b0;
        @(negedge clk);
        observe();
        check("done_falls", 32'(bus.shift_done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < HEIGHT; r++) check(tag, 32'(mem[r]), 32'(model[r]));
    endtask

    initial begin
        int  dk;
        logic saw_done;
        reset       = 1'b1;
        preload     = 1'b0;
        bus.restart = 1'b0;
        bus.clear   = 1'b0;
        bus.row     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.shift_done), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Mid-board shift
        do_preload();
        run_shift(5, dk);
        release_clear();
        for (int r = 0; r < HEIGHT; r++)
            check("mid_row", 32'(mem[r]), (r <= 5) ? 32'(r) : 32'(r + 1));

        // Bottom row
        do_preload();
        run_shift(19, dk);
        release_clear();
        for (int r = 0; r < HEIGHT; r++) check("bottom_row", 32'(mem[r]), 32'(r));

        // Top row: a single blanking write
        run_shift(0, dk);
        release_clear();
        check_board("top_board");

        // Out-of-range row clamps to the bottom
        do_preload();
        run_shift(25, dk);
        release_clear();
        check_board("oor_board");

        // Restart mid-shift: only the writes at cycles 2 and 4 land
        do_preload();
        exp_q.push_back(wr_t'{addr: ROW_W'(10), data: model[9]});
        exp_q.push_back(wr_t'{addr: ROW_W'(9), data: model[8]});
        model[10] = model[9];
        model[9]  = model[8];
        bus.row   = ROW_W'(10);
        bus.clear = 1'b1;
        saw_done  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 5) begin
                bus.restart = 1'b1;
                bus.clear   = 1'b0;
            end
            if (k == 6) begin
                bus.restart = 1'b0;
                check("restart_busy", 32'(bus.busy), 32'd0);
            end
            observe();
            if (bus.shift_done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("restart_no_done", 32'(saw_done), 32'd0);
        check("restart_queue", 32'(exp_q.size()), 32'd0);
        run_shift(3, dk);
        release_clear();
        check_board("restart_board");

        // Handshake release: shift_done held with clear, drops after it falls
        run_shift(2, dk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            observe();
            check("done_hold", 32'(bus.shift_done), 32'd1);
        end
        bus.clear = 1'b0;
        observe();
        check("done_last", 32'(bus.shift_done), 32'd1);
        @(negedge clk);
        check("done_drop", 32'(bus.shift_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            observe();
            check("idle_busy", 32'(bus.busy), 32'd0);
            @(negedge clk);
        end
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check_board("final_board");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
